// File: rtl/logistic_map_iter.sv
// rtl/logistic_map_iter.sv - logistic map x' = r*x*(1-x) iteration controller, Q2.16
module logistic_map_iter #(
    parameter int W     = 18,
    parameter int FRAC  = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [W-1:0]     r_in,
    input  logic [W-1:0]     x0_in,
    input  logic [CNT_W-1:0] n_iter,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     x_out,
    output logic             x_valid,
    input  logic             x_ready,
    output logic             mul_start,
    output logic [W-1:0]     mul_dataa,
    output logic [W-1:0]     mul_datab,
    input  logic [2*W-1:0]   mul_result,
    input  logic             mul_done
);

    localparam logic [W-1:0]     ONE     = {{(W-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_MUL1, S_WAIT1, S_MUL2, S_WAIT2, S_EMIT, S_FIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     r_q;
    logic [W-1:0]     x_q;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     prod_q;
    logic [W-1:0]     x_clamp;
    logic             unused_prod_bits;

    // Product back to Q2.16 by truncation; the top bits are zero by the map's range
    assign prod_q           = mul_result[FRAC+W-1:FRAC];
    assign unused_prod_bits = ^{mul_result[2*W-1:FRAC+W], mul_result[FRAC-1:0]};
    // Starting values above 1.0 are clamped so that 1-x can never go negative
    assign x_clamp          = (x0_in > ONE) ? ONE : x0_in;
    assign x_out            = x_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (n_iter == '0) ? S_FIN : S_MUL1;
            S_MUL1:  state_next = S_WAIT1;
            S_WAIT1: if (mul_done) state_next = S_MUL2;
            S_MUL2:  state_next = S_WAIT2;
            S_WAIT2: if (mul_done) state_next = S_EMIT;
            S_EMIT:  if (x_ready) state_next = (cnt == '0) ? S_FIN : S_MUL1;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operands are loaded on entry to a MUL state and held otherwise
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q       <= '0;
            x_q       <= '0;
            cnt       <= '0;
            mul_dataa <= '0;
            mul_datab <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_q <= r_in;
                        cnt <= n_iter;
                        x_q <= x_clamp;
                        if (n_iter != '0) begin
                            mul_dataa <= x_clamp;
                            mul_datab <= ONE - x_clamp;
                        end
                    end
                end
                S_WAIT1: begin
                    if (mul_done) begin
                        mul_dataa <= r_q;
                        mul_datab <= prod_q;
                    end
                end
                S_WAIT2: begin
                    if (mul_done) begin
                        x_q <= prod_q;
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_EMIT: begin
                    if (x_ready && cnt != '0) begin
                        mul_dataa <= x_q;
                        mul_datab <= ONE - x_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status and handshake outputs decoded from state
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        x_valid   = 1'b0;
        mul_start = 1'b0;
        case (state)
            S_IDLE:  busy = 1'b0;
            S_MUL1:  begin busy = 1'b1; mul_start = 1'b1; end
            S_MUL2:  begin busy = 1'b1; mul_start = 1'b1; end
            S_EMIT:  begin busy = 1'b1; x_valid = 1'b1; end
            S_FIN:   begin busy = 1'b1; done = 1'b1; end
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_logistic_map_iter.sv
// tb/tb_logistic_map_iter.sv - self-checking bench for logistic_map_iter
module tb_logistic_map_iter;

    localparam int W     = 18;
    localparam int FRAC  = 16;
    localparam int CNT_W = 16;
    localparam int LAT   = 19;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     r_in = '0;
    logic [W-1:0]     x0_in = '0;
    logic [CNT_W-1:0] n_iter = '0;
    logic             busy;
    logic             done;
    logic [W-1:0]     x_out;
    logic             x_valid;
    logic             x_ready = 1'b1;
    logic             mul_start;
    logic [W-1:0]     mul_dataa;
    logic [W-1:0]     mul_datab;
    logic [2*W-1:0]   mul_result = '0;
    logic             mul_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int ready_mode = 1;
    int cnt_lat = 0;
    logic [2*W-1:0] prod = '0;
    logic [W-1:0]   obs_x[$];
    logic [2*W-1:0] obs_ops[$];
    int   done_count = 0;
    int   mstart_count = 0;
    int   xvalid_count = 0;
    int   acc_cyc = 0;
    int   done_cyc = 0;
    logic busy_at_done = 1'b0;
    logic busy_after = 1'b1;
    logic prev_done = 1'b0;

    logistic_map_iter #(.W(W), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .r_in(r_in), .x0_in(x0_in),
        .n_iter(n_iter), .busy(busy), .done(done), .x_out(x_out),
        .x_valid(x_valid), .x_ready(x_ready), .mul_start(mul_start),
        .mul_dataa(mul_dataa), .mul_datab(mul_datab),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Consumer, fixed-latency multiplier and observation monitor
    always @(negedge CLK) begin
        if (ready_mode == 2) x_ready = ($urandom_range(0, 2) != 0);
        else                 x_ready = (ready_mode == 1);
        if (mul_done) mul_done = 1'b0;
        if (RST) begin
            cnt_lat = 0;
        end else begin
            if (cnt_lat > 0) begin
                cnt_lat--;
                if (cnt_lat == 0) begin
                    mul_done   = 1'b1;
                    mul_result = prod;
                end
            end
            if (mul_start) begin
                cnt_lat = LAT;
                prod = {{W{1'b0}}, mul_dataa} * {{W{1'b0}}, mul_datab};
                obs_ops.push_back({mul_dataa, mul_datab});
                mstart_count++;
            end
            if (x_valid) xvalid_count++;
            if (x_valid && x_ready) begin
                obs_x.push_back(x_out);
                acc_cyc = cyc;
            end
            if (prev_done) busy_after = busy;
            if (done) begin
                done_count++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            prev_done = done;
        end
    end

    // Reference: plain-arithmetic logistic map, value emitted at iteration k (0-based)
    function automatic logic [W-1:0] model_x(input longint r, input longint x0, input int k);
        longint x;
        longint p;
        x = (x0 > 65536) ? 65536 : x0;
        for (int i = 0; i <= k; i++) begin
            p = (x * (65536 - x)) >> 16;
            x = (r * p) >> 16;
        end
        return W'(x);
    endfunction

    // Reference: operand pair of the j-th multiply (two per iteration)
    function automatic logic [2*W-1:0] model_op(input longint r, input longint x0, input int j);
        longint x;
        longint p;
        logic [W-1:0] a;
        logic [W-1:0] b;
        x = (x0 > 65536) ? 65536 : x0;
        a = '0;
        b = '0;
        for (int i = 0; i <= j / 2; i++) begin
            p = (x * (65536 - x)) >> 16;
            if (i == j / 2) begin
                if (j % 2 == 0) begin a = W'(x); b = W'(65536 - x); end
                else            begin a = W'(r); b = W'(p); end
            end
            x = (r * p) >> 16;
        end
        return {a, b};
    endfunction

    task automatic kick(input logic [W-1:0] r, input logic [W-1:0] x0, input logic [CNT_W-1:0] n);
        @(posedge CLK); #1;
        r_in = r; x0_in = x0; n_iter = n; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_done);
        int t;
        t = 0;
        while (done_count == base_done && t < 3000) begin
            @(posedge CLK);
            t++;
        end
        checks++;
        if (done_count == base_done) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", t);
        end
        @(posedge CLK);
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks += 7;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (x_valid !== 1'b0)   begin errors++; $display("FAIL reset_x_valid: got %b expected 0", x_valid); end
        if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b expected 0", mul_start); end
        if (x_out !== '0)       begin errors++; $display("FAIL reset_x_out: got %h expected 0", x_out); end
        if (mul_dataa !== '0)   begin errors++; $display("FAIL reset_mul_dataa: got %h expected 0", mul_dataa); end
        if (mul_datab !== '0)   begin errors++; $display("FAIL reset_mul_datab: got %h expected 0", mul_datab); end
        RST = 1'b0;
    endtask

    task automatic test_fixed_point();
        int bx;
        int bd;
        logic [W-1:0] e;
        bx = obs_x.size();
        bd = done_count;
        ready_mode = 1;
        kick(18'h20000, 18'h08000, 16'd3);
        checks += 3;
        if (busy !== 1'b1)      begin errors++; $display("FAIL fp_busy_start: got %b expected 1", busy); end
        if (mul_start !== 1'b1) begin errors++; $display("FAIL fp_mul_start: got %b expected 1", mul_start); end
        if (mul_dataa !== 18'h08000) begin errors++; $display("FAIL fp_first_dataa: got %h expected 08000", mul_dataa); end
        wait_done(bd);
        checks++;
        if (obs_x.size() - bx !== 3) begin errors++; $display("FAIL fp_count: got %0d expected 3", obs_x.size() - bx); end
        for (int i = 0; i < 3 && bx + i < obs_x.size(); i++) begin
            e = model_x(64'h20000, 64'h08000, i);
            checks++;
            if (obs_x[bx+i] !== e) begin errors++; $display("FAIL fp_x%0d: got %h expected %h", i, obs_x[bx+i], e); end
        end
        checks += 4;
        if (done_count - bd !== 1) begin errors++; $display("FAIL fp_done_pulses: got %0d expected 1", done_count - bd); end
        if (done_cyc !== acc_cyc + 1) begin errors++; $display("FAIL fp_done_timing: got %0d expected %0d", done_cyc, acc_cyc + 1); end
        if (busy_at_done !== 1'b1) begin errors++; $display("FAIL fp_busy_at_done: got %b expected 1", busy_at_done); end
        if (busy_after !== 1'b0) begin errors++; $display("FAIL fp_busy_after_done: got %b expected 0", busy_after); end
    endtask

    task automatic test_operands();
        int bx;
        int bo;
        int bd;
        logic [2*W-1:0] eo;
        bx = obs_x.size();
        bo = obs_ops.size();
        bd = done_count;
        ready_mode = 1;
        kick(18'h30000, 18'h08000, 16'd2);
        wait_done(bd);
        checks += 3;
        if (obs_ops.size() - bo !== 4) begin errors++; $display("FAIL ops_count: got %0d expected 4", obs_ops.size() - bo); end
        if (obs_x.size() - bx !== 2) begin errors++; $display("FAIL ops_x_count: got %0d expected 2", obs_x.size() - bx); end
        if (obs_x.size() - bx >= 2 && (obs_x[bx] !== 18'h0C000 || obs_x[bx+1] !== 18'h09000)) begin
            errors++;
            $display("FAIL ops_x_values: got %h %h expected 0c000 09000", obs_x[bx], obs_x[bx+1]);
        end
        for (int j = 0; j < 4 && bo + j < obs_ops.size(); j++) begin
            eo = model_op(64'h30000, 64'h08000, j);
            checks++;
            if (obs_ops[bo+j] !== eo) begin errors++; $display("FAIL ops_%0d: got %h expected %h", j, obs_ops[bo+j], eo); end
        end
    endtask

    task automatic test_clamp();
        int bx;
        int bo;
        int bd;
        bx = obs_x.size();
        bo = obs_ops.size();
        bd = done_count;
        kick(18'h20000, 18'h1FFFF, 16'd1);
        wait_done(bd);
        checks += 2;
        if (obs_ops.size() <= bo || obs_ops[bo] !== {18'h10000, 18'h00000}) begin
            errors++;
            $display("FAIL clamp_ops: got %h expected %h", (obs_ops.size() > bo) ? obs_ops[bo] : '0, {18'h10000, 18'h00000});
        end
        if (obs_x.size() <= bx || obs_x[bx] !== model_x(64'h20000, 64'h1FFFF, 0)) begin
            errors++;
            $display("FAIL clamp_x: got %h expected %h", (obs_x.size() > bx) ? obs_x[bx] : 18'h3FFFF, model_x(64'h20000, 64'h1FFFF, 0));
        end
    endtask

    task automatic test_zero_iter();
        int bv;
        int bm;
        bv = xvalid_count;
        bm = mstart_count;
        kick(18'h20000, 18'h08000, 16'd0);
        checks += 3;
        if (done !== 1'b1)      begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL zero_busy: got %b expected 1", busy); end
        if (mul_start !== 1'b0) begin errors++; $display("FAIL zero_mul_start: got %b expected 0", mul_start); end
        @(posedge CLK); #1;
        repeat (3) @(posedge CLK);
        #1;
        checks += 4;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_end: got %b expected 0", busy); end
        if (xvalid_count !== bv) begin errors++; $display("FAIL zero_x_valid: got %0d expected %0d", xvalid_count, bv); end
        if (mstart_count !== bm) begin errors++; $display("FAIL zero_mul_starts: got %0d expected %0d", mstart_count, bm); end
    endtask

    task automatic test_backpressure();
        int bx;
        int bd;
        int bm;
        int t;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        e0 = model_x(64'h30000, 64'h08000, 0);
        e1 = model_x(64'h30000, 64'h08000, 1);
        bx = obs_x.size();
        bd = done_count;
        ready_mode = 0;
        kick(18'h30000, 18'h08000, 16'd2);
        t = 0;
        while (x_valid !== 1'b1 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (x_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b expected 1", x_valid); end
        bm = mstart_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (x_valid !== 1'b1 || x_out !== e0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%b x=%h expected valid=1 x=%h", i, x_valid, x_out, e0);
            end
        end
        checks++;
        if (mstart_count !== bm) begin errors++; $display("FAIL bp_no_mul: got %0d expected %0d", mstart_count, bm); end
        ready_mode = 1;
        wait_done(bd);
        checks++;
        if (obs_x.size() - bx !== 2 || obs_x[bx] !== e0 || obs_x[bx+1] !== e1) begin
            errors++;
            $display("FAIL bp_values: got %0d values expected 2 (%h %h)", obs_x.size() - bx, e0, e1);
        end
    endtask

    task automatic test_start_ignored();
        int bx;
        int bd;
        bx = obs_x.size();
        bd = done_count;
        ready_mode = 1;
        kick(18'h30000, 18'h08000, 16'd2);
        repeat (4) @(posedge CLK);
        #1;
        r_in = 18'h10000; x0_in = 18'h00000; n_iter = 16'd5; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        wait_done(bd);
        checks++;
        if (obs_x.size() - bx !== 2 || obs_x[bx] !== model_x(64'h30000, 64'h08000, 0) || obs_x[bx+1] !== model_x(64'h30000, 64'h08000, 1)) begin
            errors++;
            $display("FAIL start_busy_ignored: got %0d values expected 2", obs_x.size() - bx);
        end
    endtask

    task automatic test_reset_mid();
        int bm;
        int bx;
        int bd;
        int t;
        bm = mstart_count;
        ready_mode = 1;
        kick(18'h30000, 18'h08000, 16'd2);
        t = 0;
        while (mstart_count < bm + 2 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks += 4;
        if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        if (x_valid !== 1'b0)   begin errors++; $display("FAIL mid_rst_x_valid: got %b expected 0", x_valid); end
        if (mul_start !== 1'b0) begin errors++; $display("FAIL mid_rst_mul_start: got %b expected 0", mul_start); end
        if (x_out !== '0)       begin errors++; $display("FAIL mid_rst_x_out: got %h expected 0", x_out); end
        bx = obs_x.size();
        bd = done_count;
        kick(18'h20000, 18'h08000, 16'd1);
        wait_done(bd);
        checks++;
        if (obs_x.size() - bx !== 1 || obs_x[bx] !== 18'h08000) begin
            errors++;
            $display("FAIL mid_rst_rerun: got %0d values expected one of 08000", obs_x.size() - bx);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]     r;
        logic [W-1:0]     x0;
        logic [CNT_W-1:0] n;
        int bx;
        int bd;
        logic [W-1:0] e;
        ready_mode = 2;
        for (int run = 0; run < 6; run++) begin
            r  = W'($urandom_range(0, 18'h3FFFF));
            x0 = W'($urandom_range(0, 18'h14000));
            n  = CNT_W'($urandom_range(1, 4));
            bx = obs_x.size();
            bd = done_count;
            kick(r, x0, n);
            wait_done(bd);
            checks++;
            if (obs_x.size() - bx !== int'(n)) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d expected %0d", run, obs_x.size() - bx, n);
            end
            for (int i = 0; i < int'(n) && bx + i < obs_x.size(); i++) begin
                e = model_x(longint'(r), longint'(x0), i);
                checks++;
                if (obs_x[bx+i] !== e) begin
                    errors++;
                    $display("FAIL rand%0d_x%0d: got %h expected %h (r=%h x0=%h)", run, i, obs_x[bx+i], e, r, x0);
                end
            end
        end
        ready_mode = 1;
    endtask

    initial begin
        test_reset();
        test_fixed_point();
        test_operands();
        test_clamp();
        test_zero_iter();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logistic_map_iter.md
# logistic_map_iter

Iteration controller for the chaos-map datapath. It computes the logistic map x(n+1) = r·x(n)·(1−x(n)) in unsigned Q2.16 fixed point for a programmed number of iterations. Each step is two multiplies issued to the downstream 18×18 shift-add multiplier through a start/done handshake. Each new x is streamed to the consumer over a valid/ready port.

## Interface
- W, 18, data width (Q2.16: 2 integer bits, FRAC fractional bits)
- FRAC, 16, fractional bits; ONE = 1 << FRAC = 0x10000
- CNT_W, 16, iteration-count width
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous active-high reset
- start  in  1  begin a run (accepted only in IDLE)
- r_in  in  W  map parameter r, Q2.16, legal [0, 0x3FFFF]
- x0_in  in  W  initial x, Q2.16
- n_iter  in  CNT_W  number of iterations to emit
- busy  out  1  high from accepted start until done pulse inclusive
- done  out  1  one-cycle pulse, run finished
- x_out  out  W  iterated value, Q2.16
- x_valid  out  1  x_out valid; held until x_ready
- x_ready  in  1  consumer accepts x_out
- mul_start  out  1  one-cycle pulse, operands valid
- mul_dataa  out  W  multiplier operand A (held stable until mul_done)
- mul_datab  out  W  multiplier operand B (held stable until mul_done)
- mul_result  in  2W  unsigned product, Q4.32
- mul_done  in  1  product valid; sampled only in WAIT states

## Operation
- States: IDLE, MUL1, WAIT1, MUL2, WAIT2, EMIT, FIN.
- **IDLE**
  - start=1 latches r_in and n_iter.
  - Also latches x = min(x0_in, ONE); values above 1.0 are clamped to 0x10000.
  - n_iter=0 goes to FIN; otherwise goes to MUL1.
- **MUL1**
  - Drive mul_dataa = x and mul_datab = ONE − x (never negative, by the clamp).
  - mul_start=1 for this cycle only. Next state WAIT1.
- **WAIT1**
  - On mul_done: p = mul_result[FRAC+W-1:FRAC] (truncate, no rounding).
  - Next state MUL2.
- **MUL2**
  - Drive mul_dataa = r and mul_datab = p; mul_start pulse. Next state WAIT2.
- **WAIT2**
  - On mul_done: x = mul_result[FRAC+W-1:FRAC].
  - Decrement the remaining-iteration count. Next state EMIT.
- **EMIT**
  - x_valid=1 and x_out=x.
  - On x_ready: if count==0 go to FIN, else go to MUL1.
- **FIN**
  - done=1 for one cycle, then IDLE.
- Range: p ≤ 0.25 and r < 4, so the product is < 1.0 and bits [2W-1:FRAC+W] are always zero. No saturation is needed.
- start while busy: ignored; latched values are unchanged.
- mul_done outside WAIT1/WAIT2: ignored.
- mul_dataa/mul_datab: hold their last values in all non-MUL states.

## Timing
- **Reset:** RST=1 at a rising edge sets state=IDLE and clears busy, done, x_valid, mul_start, x_out, mul_dataa, mul_datab and the count. This applies mid-run as well; a multiply in flight is abandoned.
- **Start:** start accepted at edge k gives busy=1 from k+1 and mul_start at k+1.
- **Per iteration:** 2 MUL cycles + (L1 + L2) multiplier latency + 1 EMIT cycle + backpressure stall cycles.
  - With x_ready held high: mul_done at edge j (WAIT2) gives x_valid at j+1.
  - Next mul_start at j+2.
- **Last iteration:** x_ready accepted at edge m gives done=1 in cycle m+1 and busy=0 at m+2.
- **n_iter=0:** start at k gives done at k+1, with no x_valid.
- **x_valid/x_out:** stable while x_ready=0. No new multiply is issued until the handshake completes.

## Test plan
- Multiplier model latency 19 cycles throughout.
- r=0x20000, x0=0x08000, n_iter=3, x_ready=1
  - -> x_out 0x08000 three times (fixed point), then one done pulse.
- r=0x30000, x0=0x08000, n_iter=2
  - -> x_out 0x0C000, then 0x09000.
  - -> mul operands seen: (0x08000, 0x08000), (0x30000, 0x04000), (0x0C000, 0x04000), (0x30000, 0x03000).
- x0=0x1FFFF, r=0x20000, n_iter=1
  - -> clamped to 0x10000; first mul_datab=0.
  - -> x_out 0x00000.
- n_iter=0 -> done exactly one cycle after start; x_valid and mul_start never asserted.
- Backpressure: r=0x30000, x0=0x08000, n_iter=2, x_ready low for 10 cycles at first x_valid
  - -> x_out holds 0x0C000 stable and no mul_start occurs during the stall.
  - -> second value 0x09000 follows after accept.
- RST pulsed during WAIT2 of iteration 1
  - -> next cycle busy=0, x_valid=0, mul_start=0.
  - -> a new start with r=0x20000, x0=0x08000, n_iter=1 yields x_out 0x08000.
